pool_writeback_packer: RTL and testbench

- Sits directly downstream of the max-pool stage.
- Accepts pooled int8 pixels (valid/row/col/data; the pool stage has no backpressure), buffers them in a small FIFO, and coalesces them into byte-strobed 32-bit writes to the activation SRAM in row-major layout, 4 pixels per word.
- Counts pixels per layer and pulses done when the whole pooled map has been written.

---
 rtl/pool_writeback_packer.sv | 272 +++++++++++++++++++++++++++
 tb/tb_pool_writeback_packer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pool_writeback_packer.sv
`default_nettype none
// ============================================================================
// Module      : pool_writeback_packer
// Description : Buffers pooled int8 pixels in a small FIFO and packs them
//               into byte-strobed 32-bit row-major writes to the activation
//               SRAM, 4 pixels per word. Pulses done when the whole pooled
//               map has been written.
//               Build option POOL_WB_RELU_EN clamps negative pixels to 0
//               before they enter the FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module pool_writeback_packer #(
    parameter int MAX_N      = 64,
    parameter int N_BITS     = $clog2(MAX_N),
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [N_BITS-1:0] img_w,
    input  logic [N_BITS-1:0] img_h,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    input  logic [N_BITS-1:0] in_row,
    input  logic [N_BITS-1:0] in_col,
    input  logic [7:0]        in_data,
    output logic              mem_wr_valid,
    input  logic              mem_wr_ready,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [31:0]       mem_wr_data,
    output logic [3:0]        mem_wr_strb,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic              coord_err
);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_RUN   = 2'd1;
    localparam logic [1:0] c_S_FLUSH = 2'd2;
    localparam logic [1:0] c_S_DONE  = 2'd3;

    localparam int c_LIN_W = 2 * N_BITS;
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_ENT_W = 2 * N_BITS + 8;
    localparam logic [c_PTR_W:0] c_FIFO_FULL = (c_PTR_W + 1)'(FIFO_DEPTH);

    // Control state and per-layer configuration
    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [N_BITS-1:0]  r_img_w;
    logic [N_BITS-1:0]  r_img_h;
    logic [ADDR_W-1:0]  r_base_addr;
    logic [c_LIN_W-1:0] r_total;
    logic [c_LIN_W-1:0] r_count;
    logic               r_overflow;
    logic               r_coord_err;

    // Input FIFO: each entry is {row, col, data}
    logic [c_ENT_W-1:0] r_fifo_mem [FIFO_DEPTH];
    logic [c_PTR_W:0]   r_wr_ptr;
    logic [c_PTR_W:0]   r_rd_ptr;
    logic [c_PTR_W:0]   w_fifo_count;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic               w_push;
    logic [7:0]         w_push_data;

    // Head-of-FIFO decode
    logic [c_ENT_W-1:0] w_head;
    logic [N_BITS-1:0]  w_head_row;
    logic [N_BITS-1:0]  w_head_col;
    logic [7:0]         w_head_data;
    logic [c_LIN_W-1:0] w_linear;
    logic [ADDR_W-1:0]  w_word;
    logic [1:0]         w_lane;
    logic [3:0]         w_lane_bit;
    logic [31:0]        w_lane_data;
    logic               w_in_range;
    logic               w_conflict;
    logic               w_out_free;
    logic               w_head_avail;

    // Pop / move decisions
    logic               w_pop;
    logic               w_pop_good;
    logic               w_pop_bad;
    logic               w_pend_move;
    logic               w_start_ok;
    logic [c_LIN_W-1:0] w_start_total;

    // Pend (word being assembled) and out (word on the SRAM port) registers
    logic               r_pend_valid;
    logic [ADDR_W-1:0]  r_pend_addr;
    logic [31:0]        r_pend_data;
    logic [3:0]         r_pend_strb;
    logic               r_out_valid;
    logic [ADDR_W-1:0]  r_out_addr;
    logic [31:0]        r_out_data;
    logic [3:0]         r_out_strb;

`ifdef POOL_WB_RELU_EN
    assign w_push_data = in_data[7] ? 8'h00 : in_data;
`else
    assign w_push_data = in_data;
`endif

    assign w_start_ok    = start && ((r_state == c_S_IDLE) || (r_state == c_S_DONE));
    assign w_start_total = c_LIN_W'(img_w) * c_LIN_W'(img_h);

    assign w_fifo_count = r_wr_ptr - r_rd_ptr;
    assign w_fifo_full  = (w_fifo_count == c_FIFO_FULL);
    assign w_fifo_empty = (r_wr_ptr == r_rd_ptr);
    // A full FIFO still accepts a pixel when the head leaves in the same cycle
    assign w_push       = (r_state == c_S_RUN) && in_valid && (!w_fifo_full || w_pop);

    assign w_head      = r_fifo_mem[r_rd_ptr[c_PTR_W-1:0]];
    assign w_head_row  = w_head[c_ENT_W-1 -: N_BITS];
    assign w_head_col  = w_head[8 +: N_BITS];
    assign w_head_data = w_head[7:0];

    assign w_linear    = c_LIN_W'(w_head_row) * c_LIN_W'(r_img_w) + c_LIN_W'(w_head_col);
    assign w_word      = r_base_addr + ADDR_W'(w_linear[c_LIN_W-1:2]);
    assign w_lane      = w_linear[1:0];
    assign w_lane_bit  = 4'b0001 << w_lane;
    assign w_lane_data = {24'h000000, w_head_data} << {w_lane, 3'b000};

    assign w_in_range   = (w_head_row < r_img_h) && (w_head_col < r_img_w);
    assign w_conflict   = r_pend_valid &&
                          ((r_pend_addr != w_word) || ((r_pend_strb & w_lane_bit) != 4'b0000));
    assign w_out_free   = !r_out_valid || mem_wr_ready;
    assign w_head_avail = (r_state == c_S_RUN) && !w_fifo_empty;

    // Pop decision and pend-to-out transfer; a conflicting pixel waits for the out slot
    always_comb begin
        w_pop       = 1'b0;
        w_pop_good  = 1'b0;
        w_pop_bad   = 1'b0;
        w_pend_move = 1'b0;
        if (w_head_avail) begin
            if (!w_in_range) begin
                w_pop     = 1'b1;
                w_pop_bad = 1'b1;
            end else if (!w_conflict || w_out_free) begin
                w_pop      = 1'b1;
                w_pop_good = 1'b1;
            end
        end
        if (r_pend_valid && w_out_free &&
            ((r_pend_strb == 4'hF) || (r_state == c_S_FLUSH) ||
             (w_head_avail && w_in_range && w_conflict))) begin
            w_pend_move = 1'b1;
        end
    end

    // Next-state logic for the layer controller
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE, c_S_DONE: begin
                if (start) begin
                    w_state_nxt = (w_start_total == '0) ? c_S_DONE : c_S_RUN;
                end else if (r_state == c_S_DONE) begin
                    w_state_nxt = c_S_IDLE;
                end
            end
            c_S_RUN: begin
                if (r_count == r_total) w_state_nxt = c_S_FLUSH;
            end
            c_S_FLUSH: begin
                if (!r_pend_valid && !r_out_valid) w_state_nxt = c_S_DONE;
            end
            default: w_state_nxt = c_S_IDLE;
        endcase
    end

    // State register, layer configuration, pixel count and sticky error flags
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_S_IDLE;
            r_img_w     <= '0;
            r_img_h     <= '0;
            r_base_addr <= '0;
            r_total     <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_coord_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start_ok) begin
                r_img_w     <= img_w;
                r_img_h     <= img_h;
                r_base_addr <= base_addr;
                r_total     <= w_start_total;
                r_count     <= '0;
                r_overflow  <= 1'b0;
                r_coord_err <= 1'b0;
            end else begin
                if (w_pop_good) r_count <= r_count + 1'b1;
                if ((r_state == c_S_RUN) && in_valid && w_fifo_full && !w_pop) r_overflow <= 1'b1;
                if (w_pop_bad) r_coord_err <= 1'b1;
            end
        end
    end

    // FIFO pointers; a new layer starts from an empty FIFO
    always_ff @(posedge clk) begin
        if (reset || w_start_ok) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (w_push) r_fifo_mem[r_wr_ptr[c_PTR_W-1:0]] <= {in_row, in_col, w_push_data};
    end

    // Pend register: load a fresh word or merge a byte into the current word
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend_valid <= 1'b0;
            r_pend_addr  <= '0;
            r_pend_data  <= '0;
            r_pend_strb  <= '0;
        end else if (w_pop_good) begin
            r_pend_valid <= 1'b1;
            if (w_pend_move || !r_pend_valid) begin
                r_pend_addr <= w_word;
                r_pend_data <= w_lane_data;
                r_pend_strb <= w_lane_bit;
            end else begin
                r_pend_data <= r_pend_data | w_lane_data;
                r_pend_strb <= r_pend_strb | w_lane_bit;
            end
        end else if (w_pend_move) begin
            r_pend_valid <= 1'b0;
        end
    end

    // Out register: holds the write stable until the SRAM accepts it
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_addr  <= '0;
            r_out_data  <= '0;
            r_out_strb  <= '0;
        end else if (w_pend_move) begin
            r_out_valid <= 1'b1;
            r_out_addr  <= r_pend_addr;
            r_out_data  <= r_pend_data;
            r_out_strb  <= r_pend_strb;
        end else if (mem_wr_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign mem_wr_valid = r_out_valid;
    assign mem_wr_addr  = r_out_addr;
    assign mem_wr_data  = r_out_data;
    assign mem_wr_strb  = r_out_strb;
    assign busy         = (r_state == c_S_RUN) || (r_state == c_S_FLUSH);
    assign done         = (r_state == c_S_DONE);
    assign overflow     = r_overflow;
    assign coord_err    = r_coord_err;

endmodule
`default_nettype wire

// File: tb/tb_pool_writeback_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pool_writeback_packer
// Description : Directed self-checking bench for pool_writeback_packer.
//               Expected writes are hand-computed from the pixel patterns.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pool_writeback_packer;

    localparam int N_BITS = 6;
    localparam int ADDR_W = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [N_BITS-1:0] img_w;
    logic [N_BITS-1:0] img_h;
    logic [ADDR_W-1:0] base_addr;
    logic              in_valid;
    logic [N_BITS-1:0] in_row;
    logic [N_BITS-1:0] in_col;
    logic [7:0]        in_data;
    logic              mem_wr_valid;
    logic              mem_wr_ready;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [31:0]       mem_wr_data;
    logic [3:0]        mem_wr_strb;
    logic              busy;
    logic              done;
    logic              overflow;
    logic              coord_err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cyc = 0;
    int last_acc = 0;

    logic [ADDR_W-1:0] q_addr [$];
    logic [31:0]       q_data [$];
    logic [3:0]        q_strb [$];
    int                q_cyc  [$];

    pool_writeback_packer dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .img_w        (img_w),
        .img_h        (img_h),
        .base_addr    (base_addr),
        .in_valid     (in_valid),
        .in_row       (in_row),
        .in_col       (in_col),
        .in_data      (in_data),
        .mem_wr_valid (mem_wr_valid),
        .mem_wr_ready (mem_wr_ready),
        .mem_wr_addr  (mem_wr_addr),
        .mem_wr_data  (mem_wr_data),
        .mem_wr_strb  (mem_wr_strb),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow),
        .coord_err    (coord_err)
    );

    always #5 clk = ~clk;

    // Record every accepted SRAM write with the cycle it was accepted in
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset && mem_wr_valid && mem_wr_ready) begin
            q_addr.push_back(mem_wr_addr);
            q_data.push_back(mem_wr_data);
            q_strb.push_back(mem_wr_strb);
            q_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int w, input int h, input int base);
        img_w     = N_BITS'(w);
        img_h     = N_BITS'(h);
        base_addr = ADDR_W'(base);
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    task automatic send(input int r, input int c, input int d);
        in_valid = 1'b1;
        in_row   = N_BITS'(r);
        in_col   = N_BITS'(c);
        in_data  = 8'(d);
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        done_cyc = cyc;
        step();
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    task automatic chk_wr(input string tag, input int addr, input logic [31:0] data,
                          input logic [3:0] strb);
        check({tag, "_present"}, 32'(q_addr.size() > 0), 32'd1);
        if (q_addr.size() > 0) begin
            check({tag, "_addr"}, 32'(q_addr.pop_front()), 32'(ADDR_W'(addr)));
            check({tag, "_data"}, q_data.pop_front(), data);
            check({tag, "_strb"}, 32'(q_strb.pop_front()), 32'(strb));
            last_acc = q_cyc.pop_front();
        end
    endtask

    initial begin
        logic [31:0] exp_2x2;
        reset        = 1'b1;
        start        = 1'b0;
        img_w        = '0;
        img_h        = '0;
        base_addr    = '0;
        in_valid     = 1'b0;
        in_row       = '0;
        in_col       = '0;
        in_data      = '0;
        mem_wr_ready = 1'b1;
        repeat (3) step();

        // Reset state
        check("rst_valid",     32'(mem_wr_valid), 32'd0);
        check("rst_addr",      32'(mem_wr_addr),  32'd0);
        check("rst_data",      mem_wr_data,       32'd0);
        check("rst_strb",      32'(mem_wr_strb),  32'd0);
        check("rst_busy",      32'(busy),         32'd0);
        check("rst_done",      32'(done),         32'd0);
        check("rst_overflow",  32'(overflow),     32'd0);
        check("rst_coord_err", 32'(coord_err),    32'd0);
        reset = 1'b0;
        step();

        // 4x4 map, row-major, data = row*4+col
        do_start(4, 4, 'h100);
        check("m4_busy", 32'(busy), 32'd1);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                send(r, c, r * 4 + c);
        wait_done("m4", 50);
        check("m4_nwrites", 32'(q_addr.size()), 32'd4);
        chk_wr("m4_w0", 'h100, 32'h03020100, 4'hF);
        chk_wr("m4_w1", 'h101, 32'h07060504, 4'hF);
        chk_wr("m4_w2", 'h102, 32'h0B0A0908, 4'hF);
        chk_wr("m4_w3", 'h103, 32'h0F0E0D0C, 4'hF);
        check("m4_done_after_write", 32'(done_cyc > last_acc), 32'd1);
        check("m4_idle", 32'(busy), 32'd0);

        // 2x2 map delivered in pool-block order, includes a negative pixel
        do_start(2, 2, 0);
        send(0, 0, 5);
        send(1, 0, 7);
        send(0, 1, 8'hFD);
        send(1, 1, 1);
        wait_done("b2", 40);
`ifdef POOL_WB_RELU_EN
        exp_2x2 = 32'h01070005;
`else
        exp_2x2 = 32'h0107FD05;
`endif
        chk_wr("b2_w0", 0, exp_2x2, 4'hF);

        // Zero-sized map completes immediately
        do_start(0, 3, 'h10);
        check("z_done", 32'(done), 32'd1);
        check("z_busy", 32'(busy), 32'd0);
        step();
        check("z_done_pulse", 32'(done), 32'd0);

        // Partial word flushed at end of a 3x1 map
        do_start(3, 1, 'h20);
        send(0, 0, 'h10);
        send(0, 1, 'h11);
        send(0, 2, 'h12);
        wait_done("p3", 40);
        chk_wr("p3_w0", 'h20, 32'h00121110, 4'b0111);

        // Duplicate lane forces an early write of the same word
        do_start(3, 1, 'h30);
        send(0, 0, 'h21);
        send(0, 0, 'h22);
        send(0, 1, 'h31);
        wait_done("dup", 40);
        chk_wr("dup_w0", 'h30, 32'h00000021, 4'b0001);
        chk_wr("dup_w1", 'h30, 32'h00003122, 4'b0011);

        // Out-of-range row is dropped and not counted
        do_start(2, 1, 'h40);
        send(1, 0, 9);
        repeat (3) step();
        check("ce_flag",     32'(coord_err),     32'd1);
        check("ce_busy",     32'(busy),          32'd1);
        check("ce_nowrite",  32'(q_addr.size()), 32'd0);
        send(0, 0, 1);
        send(0, 1, 2);
        wait_done("ce", 40);
        chk_wr("ce_w0", 'h40, 32'h00000201, 4'b0011);
        check("ce_sticky", 32'(coord_err), 32'd1);

        // Backpressure: SRAM stalls while pixels keep arriving
        mem_wr_ready = 1'b0;
        do_start(8, 8, 0);
        check("bp_ce_cleared", 32'(coord_err), 32'd0);
        for (int i = 0; i < 16; i++) send(i / 8, i % 8, i);
        check("bp_valid",  32'(mem_wr_valid), 32'd1);
        check("bp_addr",   32'(mem_wr_addr),  32'd0);
        check("bp_data",   mem_wr_data,       32'h03020100);
        check("bp_strb",   32'(mem_wr_strb),  32'hF);
        check("bp_no_ovf", 32'(overflow),     32'd0);
        send(2, 0, 16);
        check("bp_ovf", 32'(overflow), 32'd1);
        for (int i = 17; i < 20; i++) send(i / 8, i % 8, i);
        check("bp_hold_valid", 32'(mem_wr_valid), 32'd1);
        check("bp_hold_addr",  32'(mem_wr_addr),  32'd0);
        check("bp_hold_data",  mem_wr_data,       32'h03020100);

        // Reset in the middle of a layer
        reset = 1'b1;
        step();
        check("mr_valid",    32'(mem_wr_valid), 32'd0);
        check("mr_addr",     32'(mem_wr_addr),  32'd0);
        check("mr_data",     mem_wr_data,       32'd0);
        check("mr_strb",     32'(mem_wr_strb),  32'd0);
        check("mr_busy",     32'(busy),         32'd0);
        check("mr_overflow", 32'(overflow),     32'd0);
        reset        = 1'b0;
        mem_wr_ready = 1'b1;
        repeat (10) step();
        check("mr_nowrite", 32'(q_addr.size()), 32'd0);

        // Clean restart after reset
        do_start(2, 2, 'h55);
        send(0, 0, 1);
        send(0, 1, 2);
        send(1, 0, 3);
        send(1, 1, 4);
        wait_done("rs", 40);
        chk_wr("rs_w0", 'h55, 32'h04030201, 4'hF);
        check("rs_no_ovf", 32'(overflow), 32'd0);
        check("rs_nextra", 32'(q_addr.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
